// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with a fixed 34-cycle latency.
// The result, destination index and write enable feed the register-file write port.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            reg_wen
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [5:0]      LAST_CNT = 6'd32;

    state_t            state_q, state_d;
    logic [5:0]        count_q, count_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        rd_q, rd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   op_a_q, op_a_d;
    logic              neg_q, neg_d;
    logic              div_zero_q, div_zero_d;
    logic              ovf_q, ovf_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;

    logic              a_signed, b_signed, a_neg, b_neg, is_div;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, div_rem_sh, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
    logic [XLEN-1:0]   div_word, div_fix, fix_result;

    // Operand decode at accept: signedness, magnitudes and corner cases.
    always_comb begin
        is_div   = funct3[2];
        a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
        b_signed = a_signed && (funct3 != 3'b010);
        a_neg    = a_signed && op_a[XLEN-1];
        b_neg    = b_signed && op_b[XLEN-1];
        a_mag    = a_neg ? (~op_a + 1'b1) : op_a;
        b_mag    = b_neg ? (~op_b + 1'b1) : op_b;
    end

    // One iteration: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
        mul_next   = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
        div_rem_sh = acc_q[2*XLEN-1:XLEN-1];
        div_ge     = div_rem_sh >= {1'b0, mcand_q};
        div_diff   = div_rem_sh - {1'b0, mcand_q};
        div_next   = div_ge ? {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                            : {div_rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end

    // Sign correction and word selection; divide corner cases override the datapath.
    always_comb begin
        prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
        div_word = funct3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        div_fix  = neg_q ? (~div_word + 1'b1) : div_word;
        if (!funct3_q[2]) begin
            fix_result = (funct3_q == 3'b000) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else if (div_zero_q) begin
            fix_result = funct3_q[1] ? op_a_q : ALL_ONES;
        end else if (ovf_q) begin
            fix_result = funct3_q[1] ? '0 : MIN_INT;
        end else begin
            fix_result = div_fix;
        end
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        funct3_d   = funct3_q;
        rd_d       = rd_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        op_a_d     = op_a_q;
        neg_d      = neg_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        result_d   = result_q;
        rd_out_d   = rd_out_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d    = RUN;
                        count_d    = '0;
                        funct3_d   = funct3;
                        rd_d       = rd_in;
                        op_a_d     = op_a;
                        acc_d      = is_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
                        mcand_d    = is_div ? b_mag : a_mag;
                        neg_d      = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
                        div_zero_d = is_div && (op_b == '0);
                        ovf_d      = is_div && !funct3[0] && (op_a == MIN_INT) && (op_b == ALL_ONES);
                    end
                end
                RUN: begin
                    if (count_q == LAST_CNT) begin
                        state_d = FIX;
                    end else begin
                        acc_d   = funct3_q[2] ? div_next : mul_next;
                        count_d = count_q + 6'd1;
                    end
                end
                FIX: begin
                    state_d  = DONE;
                    result_d = fix_result;
                    rd_out_d = rd_q;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            funct3_q   <= '0;
            rd_q       <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            op_a_q     <= '0;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            result_q   <= '0;
            rd_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            funct3_q   <= funct3_d;
            rd_q       <= rd_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            op_a_q     <= op_a_d;
            neg_q      <= neg_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
            result_q   <= result_d;
            rd_out_q   <= rd_out_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign result  = result_q;
    assign rd_out  = rd_out_q;
    assign reg_wen = done && (rd_out_q != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: scoreboarded ops, reset, flush,
// ignored starts, rd=0 handling and back-to-back issue.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        busy, done, reg_wen;
    logic [31:0] result;
    logic [4:0]  rd_out;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out),
        .reg_wen(reg_wen)
    );

    always #5 clk = ~clk;

    // Reference arithmetic built on the simulator's native operators.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0]        ub, up;
        logic [31:0]        r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'd0, b};
        r  = '0;
        case (f3)
            3'b000: begin sp = sa * sb; r = sp[31:0]; end
            3'b001: begin sp = sa * sb; r = sp[63:32]; end
            3'b010: begin sp = sa * $signed(ub); r = sp[63:32]; end
            3'b011: begin up = {32'd0, a} * ub; r = up[63:32]; end
            3'b100: r = (b == 0) ? 32'hFFFFFFFF :
                        (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h80000000 :
                        32'($signed(a) / $signed(b));
            3'b101: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'b110: r = (b == 0) ? a :
                        (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'd0 :
                        32'($signed(a) % $signed(b));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_res, input bit track);
        exp_t e;
        start  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        if (track) begin
            e.res = exp_res;
            e.rd  = rd;
            sb_q.push_back(e);
        end
        @(negedge clk);
        start  = 1'b0;
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
        rd_in  = 5'($urandom);
    endtask

    // Counts edges since accept (the first negedge after accept is 0) until done or limit.
    task automatic wait_done(input int start_at, input int limit, output int cycles, output bit seen);
        cycles = start_at;
        seen   = 1'b0;
        while (!seen && cycles < limit) begin
            if (done === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                cycles++;
            end
        end
        if (!seen && done === 1'b1) seen = 1'b1;
    endtask

    task automatic pop_expected(output exp_t e, output bit ok);
        ok = sb_q.size() != 0;
        if (ok) e = sb_q.pop_front();
        else begin
            e.res = 'x;
            e.rd  = 'x;
        end
    endtask

    task automatic test_reset();
        int   lat;
        bit   seen, ok;
        exp_t e;
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy, done, reg_wen, result, rd_out} !== 40'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got busy=%b done=%b wen=%b result=%h rd=%0d, want all zero",
                     busy, done, reg_wen, result, rd_out);
        end
        rst = 1'b0;
        @(negedge clk);
        issue(3'b000, 32'd5, 32'd5, 5'd3, 32'd25, 1'b1);
        wait_done(0, 60, lat, seen);
        pop_expected(e, ok);
        n_tests++;
        if (!ok || !seen || result !== e.res) begin
            n_fail++;
            $display("[TB] FAIL reset_preop: seen=%b got %h, want %h", seen, result, e.res);
        end
        @(negedge clk);
        issue(3'b000, 32'h1234, 32'h5678, 5'd7, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if ({busy, done, reg_wen, result, rd_out} !== 40'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_midrun: got busy=%b done=%b wen=%b result=%h rd=%0d, want all zero",
                     busy, done, reg_wen, result, rd_out);
        end
        wait_done(0, 50, lat, seen);
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("[TB] FAIL reset_nodone: got done after %0d cycles, want no done", lat);
        end
        issue(3'b000, 32'd6, 32'd7, 5'd1, 32'd42, 1'b1);
        wait_done(0, 60, lat, seen);
        pop_expected(e, ok);
        n_tests++;
        if (!ok || !seen || lat != 34 || result !== e.res) begin
            n_fail++;
            $display("[TB] FAIL reset_mul6x7: seen=%b lat=%0d result=%h, want lat=34 result=%h",
                     seen, lat, result, e.res);
        end
        @(negedge clk);
    endtask

    task automatic test_vectors(input string tag, input vec_t vecs[$]);
        int   lat;
        bit   seen, ok;
        exp_t e;
        foreach (vecs[i]) begin
            issue(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].res, 1'b1);
            wait_done(0, 60, lat, seen);
            pop_expected(e, ok);
            n_tests++;
            if (!ok || !seen || lat != 34) begin
                n_fail++;
                $display("[TB] FAIL %s_latency[%0d]: seen=%b lat=%0d, want 34", tag, i, seen, lat);
            end
            n_tests++;
            if (result !== e.res || rd_out !== e.rd || reg_wen !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL %s_result[%0d] f3=%0d a=%h b=%h: got %h rd=%0d wen=%b, want %h rd=%0d wen=1",
                         tag, i, vecs[i].f3, vecs[i].a, vecs[i].b, result, rd_out, reg_wen, e.res, e.rd);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mul();
        vec_t vecs[$];
        logic [31:0] a, b;
        vecs.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000});
        vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
        vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF});
        vecs.push_back('{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001});
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            vecs.push_back('{3'(i), a, b, model(3'(i), a, b)});
        end
        test_vectors("mul", vecs);
    endtask

    task automatic test_div();
        vec_t vecs[$];
        logic [31:0] a, b;
        vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD});
        vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF});
        vecs.push_back('{3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC});
        vecs.push_back('{3'b101, 32'h1234, 32'd0, 32'hFFFFFFFF});
        vecs.push_back('{3'b110, 32'h1234, 32'd0, 32'h1234});
        vecs.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000});
        vecs.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000});
        for (int i = 4; i < 8; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(28, 0);
            vecs.push_back('{3'(i), a, b, model(3'(i), a, b)});
        end
        test_vectors("div", vecs);
    endtask

    task automatic test_rd_zero();
        int   lat;
        bit   seen, ok;
        exp_t e;
        issue(3'b000, 32'd3, 32'd3, 5'd0, 32'd9, 1'b1);
        wait_done(0, 60, lat, seen);
        pop_expected(e, ok);
        n_tests++;
        if (!ok || !seen || result !== e.res || reg_wen !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rd0_nowen: seen=%b result=%h wen=%b, want done result=%h wen=0",
                     seen, result, reg_wen, e.res);
        end
        @(negedge clk);
        issue(3'b000, 32'd3, 32'd3, 5'd5, 32'd9, 1'b1);
        wait_done(0, 60, lat, seen);
        pop_expected(e, ok);
        n_tests++;
        if (!ok || !seen || result !== e.res || reg_wen !== 1'b1 || rd_out !== 5'd5) begin
            n_fail++;
            $display("[TB] FAIL rd5_wen: seen=%b result=%h wen=%b rd=%0d, want result=%h wen=1 rd=5",
                     seen, result, reg_wen, rd_out, e.res);
        end
        @(negedge clk);
        n_tests++;
        if (reg_wen !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rd5_onecycle: got wen=%b done=%b busy=%b, want 0 0 0", reg_wen, done, busy);
        end
    endtask

    task automatic test_start_during_run();
        int   lat;
        bit   seen, ok;
        exp_t e;
        issue(3'b101, 32'd100, 32'd7, 5'd4, 32'd14, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1; funct3 = 3'b000; op_a = 32'd1000; op_b = 32'd1000; rd_in = 5'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done(5, 60, lat, seen);
        pop_expected(e, ok);
        n_tests++;
        if (!ok || !seen || lat != 34 || result !== e.res || rd_out !== e.rd) begin
            n_fail++;
            $display("[TB] FAIL start_ignored: seen=%b lat=%0d result=%h rd=%0d, want lat=34 result=%h rd=%0d",
                     seen, lat, result, rd_out, e.res, e.rd);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL start_ignored_idle: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_flush();
        int lat;
        bit seen;
        issue(3'b000, 32'd9, 32'd9, 5'd2, 32'd0, 1'b0);
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_idle: got busy=%b, want 0", busy);
        end
        wait_done(0, 50, lat, seen);
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("[TB] FAIL flush_nodone: got done after %0d cycles, want none", lat);
        end
        flush = 1'b1; start = 1'b1; funct3 = 3'b000; op_a = 32'd2; op_b = 32'd2; rd_in = 5'd3;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_start_busy: got busy=%b, want 0", busy);
        end
        wait_done(0, 50, lat, seen);
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("[TB] FAIL flush_start_nodone: got done after %0d cycles, want none", lat);
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        bit   seen, ok;
        exp_t e, e2;
        issue(3'b000, 32'd11, 32'd13, 5'd9, 32'd143, 1'b1);
        wait_done(0, 60, lat, seen);
        pop_expected(e, ok);
        n_tests++;
        if (!ok || !seen || result !== e.res) begin
            n_fail++;
            $display("[TB] FAIL b2b_first: seen=%b result=%h, want %h", seen, result, e.res);
        end
        start = 1'b1; funct3 = 3'b100; op_a = 32'd100; op_b = 32'hFFFFFFFD; rd_in = 5'd10;
        e2.res = 32'hFFFFFFDF;
        e2.rd  = 5'd10;
        sb_q.push_back(e2);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_done_ignored: got busy=%b, want 0", busy);
        end
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL b2b_accept: got busy=%b, want 1", busy);
        end
        wait_done(0, 60, lat, seen);
        pop_expected(e, ok);
        n_tests++;
        if (!ok || !seen || lat != 34 || result !== e.res || rd_out !== e.rd) begin
            n_fail++;
            $display("[TB] FAIL b2b_second: seen=%b lat=%0d result=%h rd=%0d, want lat=34 result=%h rd=%0d",
                     seen, lat, result, rd_out, e.res, e.rd);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_rd_zero();
        test_start_during_run();
        test_flush();
        test_back_to_back();
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_empty: got %0d leftover entries, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
